uart_receive: RTL and testbench

// - Serial-to-parallel receiver; sits directly downstream of the UART transmitter and consumes its tx line.
// - Deserialises one bit per clock (baud = clk): start bit 0, D_WIDTH data bits LSB first, stop bit 1.
// - Presents each good word on a valid/ready output with a 1-entry holding register.
// - Flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_receive.sv | 127 ++++++++++++
 tb/tb_uart_receive.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default word width and receiver state encoding.
package uart_pkg;

    localparam int unsigned UART_D_WIDTH = 13;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t RX_IDLE      = 2'd0;
    localparam rx_state_t RX_DATA      = 2'd1;
    localparam rx_state_t RX_STOP      = 2'd2;
    localparam rx_state_t RX_WAIT_IDLE = 2'd3;

endpackage

// File: rtl/uart_rx_sync.sv
// Serial input synchroniser; flops reset to the idle line level (1).
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s_o
);

    if (SYNC_STAGES == 0) begin : g_bypass
        assign rx_s_o = rx_i;
    end else begin : g_chain
        logic [SYNC_STAGES-1:0] sync_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q <= '1;
            end else begin
                sync_q[0] <= rx_i;
                for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign rx_s_o = sync_q[SYNC_STAGES-1];
    end

endmodule

// File: rtl/uart_receive.sv
// UART receiver: one bit per clock, start/data(LSB first)/stop, with a
// 1-entry valid/ready holding register and framing/overrun pulses.
module uart_receive
    import uart_pkg::*;
#(
    parameter int unsigned D_WIDTH     = UART_D_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               rx_busy,
    output logic               rx_frame_err,
    output logic               rx_overrun
);

    localparam int unsigned CNT_W = $clog2(D_WIDTH + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(D_WIDTH - 1);

    logic               rx_s;
    rx_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [D_WIDTH-1:0] shift_q, shift_d;
    logic [D_WIDTH-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, err_q, ovr_q;
    logic               frame_good, frame_bad, overrun_d;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .rx_i  (rx),
        .rx_s_o(rx_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_DATA;
                    cnt_d   = '0;
                end
            end
            RX_DATA: begin
                shift_d = {rx_s, shift_q[D_WIDTH-1:1]};
                if (cnt_q == CntLast) begin
                    state_d = RX_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_s) begin
                    state_d    = RX_IDLE;
                    frame_good = 1'b1;
                end else begin
                    state_d   = RX_WAIT_IDLE;
                    frame_bad = 1'b1;
                end
            end
            RX_WAIT_IDLE: begin
                // A stuck-low line must return high before a new start bit counts.
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (frame_good && (!valid_q || rx_ready)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else begin
            if (frame_good) begin
                overrun_d = 1'b1;
            end
            if (valid_q && rx_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != RX_IDLE);
            err_q   <= frame_bad;
            ovr_q   <= overrun_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_busy      = busy_q;
    assign rx_frame_err = err_q;
    assign rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive: schedule-based reference model plus directed literal checks.
module tb_uart_receive;

    localparam int D    = 13;
    localparam int S    = 2;
    localparam int MAXC = 2048;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rx = 1'b1;
    logic         rx_ready = 1'b0;
    logic [D-1:0] rx_data;
    logic         rx_valid, rx_busy, rx_frame_err, rx_overrun;

    always #5 clk = ~clk;

    uart_receive #(
        .D_WIDTH    (D),
        .SYNC_STAGES(S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_busy     (rx_busy),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun)
    );

    // Stimulus schedule (index = pin cycle before edge n) and expected events per edge.
    bit           rx_a   [MAXC];
    bit           rdy_a  [MAXC];
    bit           good_at[MAXC];
    bit           err_at [MAXC];
    bit           busy_at[MAXC];
    logic [D-1:0] word_at[MAXC];
    int           ncyc;

    int n_assert = 0;
    int n_fail   = 0;
    int first_valid, valid_cycles, err_seen, ov_seen, busy_cycles;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endfunction

    function automatic void clear_sched(bit rdy);
        for (int i = 0; i < MAXC; i++) begin
            rx_a[i]    = 1'b1;
            rdy_a[i]   = rdy;
            good_at[i] = 1'b0;
            err_at[i]  = 1'b0;
            busy_at[i] = 1'b0;
            word_at[i] = '0;
        end
        ncyc = 0;
    endfunction

    function automatic void add_idle(int n);
        ncyc += n;
    endfunction

    // A frame starting at pin cycle k is seen by the FSM at edge k+S and its
    // stop bit is judged at edge k+S+D+1.
    function automatic void add_frame(logic [D-1:0] w, bit bad, int low_extra);
        int k, h;
        k = ncyc;
        rx_a[k] = 1'b0;
        for (int i = 0; i < D; i++) rx_a[k+1+i] = w[i];
        rx_a[k+D+1] = !bad;
        for (int e = k + S; e <= k + S + D; e++) busy_at[e] = 1'b1;
        if (!bad) begin
            good_at[k+S+D+1] = 1'b1;
            word_at[k+S+D+1] = w;
            ncyc = k + D + 2;
        end else begin
            err_at[k+S+D+1] = 1'b1;
            for (int j = 1; j <= low_extra; j++) rx_a[k+D+1+j] = 1'b0;
            h = k + D + 2 + low_extra;
            for (int e = k + S + D + 1; e <= h + S - 1; e++) busy_at[e] = 1'b1;
            ncyc = h + 1;
        end
    endfunction

    task automatic do_reset();
        rst      = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Entered at a negedge with the DUT freshly out of reset.
    task automatic run_sched();
        logic         mv, exp_ov;
        logic [D-1:0] md;
        mv = 1'b0;
        md = '0;
        first_valid  = -1;
        valid_cycles = 0;
        err_seen     = 0;
        ov_seen      = 0;
        busy_cycles  = 0;
        for (int n = 0; n < ncyc + S + 3; n++) begin
            rx       = rx_a[n];
            rx_ready = rdy_a[n];
            @(posedge clk);
            exp_ov = 1'b0;
            if (good_at[n]) begin
                if (!mv || rdy_a[n]) begin
                    mv = 1'b1;
                    md = word_at[n];
                end else begin
                    exp_ov = 1'b1;
                end
            end else if (mv && rdy_a[n]) begin
                mv = 1'b0;
            end
            @(negedge clk);
            check($sformatf("cycle %0d {valid,data,busy,ferr,ovr}", n),
                  {rx_valid, rx_data, rx_busy, rx_frame_err, rx_overrun},
                  {mv, md, busy_at[n], err_at[n], exp_ov});
            if (rx_valid && first_valid < 0) first_valid = n;
            if (rx_valid) valid_cycles++;
            if (rx_frame_err) err_seen++;
            if (rx_overrun) ov_seen++;
            if (rx_busy) busy_cycles++;
        end
    endtask

    initial begin
        // Reset held with rx toggling, then released on an idle line.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx = i[0];
            @(posedge clk);
            @(negedge clk);
            check("reset outputs", {rx_valid, rx_data, rx_busy, rx_frame_err, rx_overrun}, 0);
        end
        rx  = 1'b1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("idle after reset busy", rx_busy, 0);
        check("idle after reset valid", rx_valid, 0);

        // Single good frame, consumer always ready.
        clear_sched(1'b1);
        add_idle(3);
        add_frame(13'h1A5C, 1'b0, 0);
        add_idle(4);
        do_reset();
        run_sched();
        check("single first valid edge", first_valid, 19);
        check("single data", rx_data, 13'h1A5C);
        check("single valid cycles", valid_cycles, 1);
        check("single error pulses", err_seen + ov_seen, 0);

        // Stop bit low, line held low 5 more cycles.
        clear_sched(1'b1);
        add_idle(3);
        add_frame(13'h0FFF, 1'b1, 5);
        add_idle(3);
        do_reset();
        run_sched();
        check("framing err pulses", err_seen, 1);
        check("framing valid cycles", valid_cycles, 0);
        check("framing busy cycles", busy_cycles, 20);

        // Back-to-back frames, consumer never ready.
        clear_sched(1'b0);
        add_idle(3);
        add_frame(13'h0001, 1'b0, 0);
        add_frame(13'h1FFF, 1'b0, 0);
        add_idle(4);
        do_reset();
        run_sched();
        check("overrun pulses", ov_seen, 1);
        check("overrun kept data", rx_data, 13'h0001);
        check("overrun valid", rx_valid, 1);

        // Ready only on the second frame's stop edge.
        clear_sched(1'b0);
        add_idle(3);
        add_frame(13'h0001, 1'b0, 0);
        add_frame(13'h1FFF, 1'b0, 0);
        add_idle(4);
        rdy_a[34] = 1'b1;
        do_reset();
        run_sched();
        check("swap data", rx_data, 13'h1FFF);
        check("swap valid", rx_valid, 1);
        check("swap overrun pulses", ov_seen, 0);

        // Reset after 6 data bits, then a clean frame.
        do_reset();
        for (int i = 0; i < 7 + S; i++) begin
            rx = (i == 0) ? 1'b0 : i[0];
            @(negedge clk);
        end
        check("midframe busy", rx_busy, 1);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rx = i[0];
            check("midframe reset outputs",
                  {rx_valid, rx_data, rx_busy, rx_frame_err, rx_overrun}, 0);
        end
        clear_sched(1'b1);
        add_idle(2);
        add_frame(13'h0AAA, 1'b0, 0);
        add_idle(4);
        rst = 1'b1;
        run_sched();
        check("after reset data", rx_data, 13'h0AAA);
        check("after reset valid cycles", valid_cycles, 1);
        check("after reset error pulses", err_seen + ov_seen, 0);

        // Randomised frames, gaps, breaks and consumer back-pressure.
        clear_sched(1'b0);
        for (int i = 0; i < 40; i++) begin
            add_idle($urandom_range(0, 3));
            add_frame(D'($urandom), ($urandom_range(0, 5) == 0), $urandom_range(0, 4));
        end
        add_idle(4);
        for (int i = 0; i < MAXC; i++) rdy_a[i] = $urandom_range(0, 1) == 1;
        do_reset();
        run_sched();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
